vblank_copy_sequencer: RTL and testbench
========================================

# vblank_copy_sequencer

Sequences the vertical-blank transfer between data memory and the GPU. On each `copy_start` pulse it streams the rectangle table from data memory into the GPU rect buffer, then optionally writes the sampled button state back to data memory, and finally pulses `done`. It owns the data-memory port only while the `copy` flag is high and sits between `brus16_controller`, the data-memory mux and the GPU rect buffer.

## Interface
- `RECT_COUNT`, 64: number of rectangles transferred per frame.
- `RECT_WORDS`, 5: 16-bit words per rectangle (x, y, w, h, colour).
- `ADDR_WIDTH`, 13: data-memory address width.
- `RECT_BASE`, 13'h0100: data-memory address of rect word 0.
- `BUTTON_ADDR`, 13'h00FF: data-memory address for the button word.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `copy_start`  in  1  one-cycle start pulse.
- `copy`  in  1  copy window flag; sequencer may drive memory only while high.
- `buttons`  in  16  raw button state.
- `mem_addr`  out  ADDR_WIDTH  data-memory address.
- `mem_re`  out  1  read strobe; data valid on `mem_rdata` the next cycle.
- `mem_rdata`  in  16  read data.
- `mem_we`  out  1  write strobe.
- `mem_wdata`  out  16  write data.
- `gpu_we`  out  1  rect-buffer write strobe.
- `gpu_addr`  out  $clog2(RECT_COUNT*RECT_WORDS)  rect-buffer word index.
- `gpu_wdata`  out  16  rect-buffer data.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `overrun`  out  1  sticky flag: the last transfer was aborted.

## Operation
- N = RECT_COUNT*RECT_WORDS. Elaboration error if RECT_BASE+N-1 ≥ 2^ADDR_WIDTH.
- States:
  - IDLE: waits for work.
  - READ: issues reads for k = 0..N-1.
  - DRAIN: performs the final GPU write.
  - BTN: writes the button word (macro only).
  - DONE: pulses `done`.
- IDLE→READ on `copy_start && copy`. `copy_start` without `copy` is ignored. Entering READ clears `overrun` and the counter k.
- READ: `mem_re`=1, `mem_addr`=RECT_BASE+k, k increments each cycle. After k=N-1, go to DRAIN.
- Write pipeline: 1-cycle registered. A read issued for index k produces, in the following cycle, `gpu_we`=1, `gpu_addr`=k, `gpu_wdata`=`mem_rdata`.
- DRAIN: no read; the final GPU write (k=N-1) occurs. Next state is BTN, or DONE if the macro is absent.
- BTN: `mem_we`=1, `mem_addr`=BUTTON_ADDR, `mem_wdata`=`buttons` sampled that cycle. Next state is DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `copy_start` while not in IDLE is ignored.
- Abort: if `copy` is low in READ, DRAIN or BTN, the next state is IDLE. All strobes are low from that cycle, the pending GPU write is dropped, `overrun` is set, and `done` is not pulsed.
- `mem_re`, `mem_we` and `gpu_we` are never high while `copy` is low.

## Timing
- Reset values: all strobes 0, addresses and data 0, `busy`=0, `done`=0, `overrun`=0, state IDLE, k=0. Reset mid-transfer returns to IDLE immediately; no partial writes after reset.
- Let c be the cycle in which `copy_start` is sampled:
  - Reads are issued in cycles c+1 .. c+N.
  - GPU writes occur in cycles c+2 .. c+N+1.
  - With the macro: the button write occurs at c+N+2 and `done` at c+N+3.
  - Without the macro: `done` at c+N+2.
- `busy` is high from c+1 through the cycle before `done`. It is low in the `done` cycle.
- Throughput: one word per cycle, with no bubbles.

## Configuration
- `VBLANK_BUTTON_WRITE_EN` defined: the BTN state exists and the button word is written once per completed transfer.
- `VBLANK_BUTTON_WRITE_EN` undefined: no BTN state, `mem_we` and `mem_wdata` are tied to 0, `buttons` is unused, and latency is one cycle shorter.

## Structure
- `brus16_pkg` holds:
  - the DATA_WIDTH=16 constant;
  - the default RECT_WORDS;
  - the `copy_state_t` enum (IDLE, READ, DRAIN, BTN, DONE).
- One natural sub-module, `copy_addr_counter`. It is a loadable index counter with a terminal-count output (k==N-1) and clear. It is instantiated once.

## Test plan
All scenarios use RECT_COUNT=2, RECT_WORDS=5 (N=10), RECT_BASE=0x100 and macro on.
- Memory word i = 0xA000+i, `copy_start` at cycle 10 → reads of 0x100..0x109 in cycles 11–20, GPU writes of index i with 0xA000+i in cycles 12–21.
- Same transfer with `buttons`=0x00C3 → `mem_we` at cycle 22 to 0x0FF with 0x00C3, `done` pulse at cycle 23, `busy` low at cycle 23.
- `copy` dropped at cycle 15 → no strobes from cycle 15, `overrun`=1, no `done`. Next `copy_start` clears `overrun` and completes normally.
- `copy_start` pulsed again at cycle 14 during a transfer → ignored; the address sequence is unchanged.
- `copy_start` with `copy`=0 → stays IDLE, all outputs 0.
- `reset` asserted at cycle 16 → all outputs 0 at cycle 17, no further writes.

Source files
------------

// File: rtl/brus16_pkg.sv
// Shared constants and types for the brus16 vblank copy path.
package brus16_pkg;

  localparam int DATA_WIDTH         = 16;
  localparam int RECT_WORDS_DEFAULT = 5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    BTN,
    DONE
  } copy_state_t;

endpackage

// File: rtl/copy_addr_counter.sv
// Loadable rect-word index counter with a terminal-count flag at k == N-1.
module copy_addr_counter #(
  parameter  int N  = 10,
  localparam int KW = $clog2(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [KW-1:0] load_val,
  input  logic          inc,
  output logic [KW-1:0] k,
  output logic          tc
);

  // Clear has priority over load, load over increment.
  always_ff @(posedge clk) begin
    if (clr) begin
      k <= '0;
    end else if (load) begin
      k <= load_val;
    end else if (inc) begin
      k <= k + KW'(1);
    end
  end

  assign tc = (k == KW'(N - 1));

endmodule

// File: rtl/vblank_copy_sequencer.sv
// Vertical-blank copy sequencer: streams the rect table from data memory into
// the GPU rect buffer, optionally writes back the button word, then pulses done.
// Optional feature macro: VBLANK_BUTTON_WRITE_EN enables the button write-back
// state; without it mem_we/mem_wdata are tied low and buttons is unused.
module vblank_copy_sequencer
  import brus16_pkg::*;
#(
  parameter  int                    RECT_COUNT  = 64,
  parameter  int                    RECT_WORDS  = RECT_WORDS_DEFAULT,
  parameter  int                    ADDR_WIDTH  = 13,
  parameter  logic [ADDR_WIDTH-1:0] RECT_BASE   = 13'h0100,
  parameter  logic [ADDR_WIDTH-1:0] BUTTON_ADDR = 13'h00FF,
  localparam int                    N           = RECT_COUNT * RECT_WORDS,
  localparam int                    GW          = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  copy_start,
  input  logic                  copy,
  input  logic [DATA_WIDTH-1:0] buttons,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  gpu_we,
  output logic [GW-1:0]         gpu_addr,
  output logic [DATA_WIDTH-1:0] gpu_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  if (N < 2) begin : g_bad_n
    $error("vblank_copy_sequencer: RECT_COUNT*RECT_WORDS must be at least 2");
  end
  if (int'(RECT_BASE) + N - 1 >= (1 << ADDR_WIDTH)) begin : g_bad_base
    $error("vblank_copy_sequencer: rect table does not fit in the address space");
  end

  copy_state_t           state;
  logic [GW-1:0]         k;
  logic                  tc;
  logic                  start_go;
  logic                  cnt_inc;
  logic                  in_window;
  logic                  mem_re_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overrun_q;
  logic                  vld_p1;
  logic [GW-1:0]         gpu_addr_p1;
`ifdef VBLANK_BUTTON_WRITE_EN
  logic                  mem_we_q;
`endif

  assign start_go  = (state == IDLE) && copy_start && copy;
  assign cnt_inc   = (state == READ) && copy && !tc;
  assign in_window = (state != IDLE) && (state != DONE);

  copy_addr_counter #(
    .N (N)
  ) u_copy_addr_counter (
    .clk      (clk),
    .clr      (reset),
    .load     (start_go),
    .load_val ('0),
    .inc      (cnt_inc),
    .k        (k),
    .tc       (tc)
  );

  // Transfer FSM; strobes and addresses are registered here, the copy flag
  // gates them at the outputs so losing the window silences them at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef VBLANK_BUTTON_WRITE_EN
      mem_we_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (in_window && !copy) begin
        // Window lost mid-transfer: abandon it and flag the overrun.
        state      <= IDLE;
        mem_re_q   <= 1'b0;
        mem_addr_q <= '0;
        busy_q     <= 1'b0;
        overrun_q  <= 1'b1;
`ifdef VBLANK_BUTTON_WRITE_EN
        mem_we_q   <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start_go) begin
              state      <= READ;
              mem_re_q   <= 1'b1;
              mem_addr_q <= RECT_BASE;
              busy_q     <= 1'b1;
              overrun_q  <= 1'b0;
            end
          end
          READ: begin
            if (tc) begin
              state      <= DRAIN;
              mem_re_q   <= 1'b0;
              mem_addr_q <= '0;
            end else begin
              mem_addr_q <= RECT_BASE + ADDR_WIDTH'(k) + ADDR_WIDTH'(1);
            end
          end
          DRAIN: begin
`ifdef VBLANK_BUTTON_WRITE_EN
            state      <= BTN;
            mem_we_q   <= 1'b1;
            mem_addr_q <= BUTTON_ADDR;
`else
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
`endif
          end
`ifdef VBLANK_BUTTON_WRITE_EN
          BTN: begin
            state      <= DONE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
`endif
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Stage p1 control: a read accepted this cycle becomes a GPU write next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= (state == READ) && copy;
    end
  end

  // Stage p1 data: rect-buffer index of the read in flight.
  always_ff @(posedge clk) begin
    gpu_addr_p1 <= k;
  end

  assign mem_re    = mem_re_q & copy;
  assign mem_addr  = mem_addr_q;
  assign gpu_we    = vld_p1 & copy;
  assign gpu_addr  = vld_p1 ? gpu_addr_p1 : '0;
  assign gpu_wdata = gpu_we ? mem_rdata : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

`ifdef VBLANK_BUTTON_WRITE_EN
  assign mem_we    = mem_we_q & copy;
  assign mem_wdata = mem_we ? buttons : '0;
`else
  logic unused_buttons;
  assign unused_buttons = ^buttons;
  assign mem_we         = 1'b0;
  assign mem_wdata      = '0;
`endif

endmodule

// File: tb/tb_vblank_copy_sequencer.sv
// Directed table-driven bench for vblank_copy_sequencer (RECT_COUNT=2, RECT_WORDS=5).
module tb_vblank_copy_sequencer;

  localparam int RC = 2;
  localparam int RW = 5;
  localparam int N  = RC * RW;
  localparam int AW = 13;
  localparam int GW = $clog2(N);
`ifdef VBLANK_BUTTON_WRITE_EN
  localparam bit BTN_EN = 1'b1;
`else
  localparam bit BTN_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          copy_start;
  logic          copy;
  logic [15:0]   buttons;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [15:0]   mem_rdata;
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic          gpu_we;
  logic [GW-1:0] gpu_addr;
  logic [15:0]   gpu_wdata;
  logic          busy;
  logic          done;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    bit          start;
    bit          cp;
    logic [15:0] btn;
    bit          re;
    bit          we;
    bit          gwe;
    bit          bsy;
    bit          dn;
    bit          ovr;
    bit          busy_x;
    bit          zero;
    logic [12:0] maddr;
    logic [15:0] mwdata;
    logic [3:0]  gaddr;
    logic [15:0] gwdata;
  } vec_t;

  vec_t tbl[$];

  vblank_copy_sequencer #(
    .RECT_COUNT  (RC),
    .RECT_WORDS  (RW),
    .ADDR_WIDTH  (AW),
    .RECT_BASE   (13'h0100),
    .BUTTON_ADDR (13'h00FF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .copy_start (copy_start),
    .copy       (copy),
    .buttons    (buttons),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .gpu_we     (gpu_we),
    .gpu_addr   (gpu_addr),
    .gpu_wdata  (gpu_wdata),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: word at 0x100+i holds 0xA000+i, one-cycle read latency.
  always @(posedge clk) begin
    mem_rdata <= mem_re ? (16'hA000 + 16'(mem_addr - 13'h100)) : 16'h0000;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit start, input bit cp, input logic [15:0] btn);
    vec_t v;
    v = '{default: '0};
    v.start = start;
    v.cp    = cp;
    v.btn   = btn;
    return v;
  endfunction

  // Expected rows of one transfer: start row, N reads, drain, [button], done, one idle row.
  task automatic add_transfer(input logic [15:0] btn, input int restart_row,
                              input bit ovr0, input int stop_row);
    vec_t v;
    int   total;
    int   lim;
    total = N + (BTN_EN ? 5 : 4);
    lim   = (stop_row >= 0) ? stop_row : total;
    for (int j = 0; j < lim; j++) begin
      v = mk((j == 0) || (j == restart_row), 1'b1, btn);
      if (j == 0) begin
        v.ovr = ovr0;
      end else if (j <= N) begin
        v.re    = 1'b1;
        v.maddr = 13'h100 + 13'(j - 1);
        v.bsy   = 1'b1;
        if (j >= 2) begin
          v.gwe    = 1'b1;
          v.gaddr  = 4'(j - 2);
          v.gwdata = 16'hA000 + 16'(j - 2);
        end
      end else if (j == N + 1) begin
        v.gwe    = 1'b1;
        v.gaddr  = 4'(N - 1);
        v.gwdata = 16'hA000 + 16'(N - 1);
        v.bsy    = 1'b1;
      end else if (BTN_EN && (j == N + 2)) begin
        v.we     = 1'b1;
        v.maddr  = 13'h0FF;
        v.mwdata = btn;
        v.bsy    = 1'b1;
      end else if (j == total - 2) begin
        v.dn = 1'b1;
      end
      tbl.push_back(v);
    end
  endtask

  task automatic apply_row(input vec_t v, input string nm);
    logic [5:0] act_ctl;
    logic [5:0] exp_ctl;
    @(posedge clk);
    #1;
    reset      = v.rst;
    copy_start = v.start;
    copy       = v.cp;
    buttons    = v.btn;
    @(negedge clk);
    act_ctl = {mem_re, mem_we, gpu_we, (v.busy_x ? v.bsy : busy), done, overrun};
    exp_ctl = {v.re, v.we, v.gwe, v.bsy, v.dn, v.ovr};
    check({nm, " re/we/gwe/busy/done/ovr"}, 32'(act_ctl), 32'(exp_ctl));
    if (v.re || v.we) check({nm, " mem_addr"}, 32'(mem_addr), 32'(v.maddr));
    if (v.we) check({nm, " mem_wdata"}, 32'(mem_wdata), 32'(v.mwdata));
    if (v.gwe) begin
      check({nm, " gpu_addr"}, 32'(gpu_addr), 32'(v.gaddr));
      check({nm, " gpu_wdata"}, 32'(gpu_wdata), 32'(v.gwdata));
    end
    if (v.zero) begin
      check({nm, " zero addr/data"}, {3'b0, mem_addr, gpu_addr, 12'b0}, 32'h0);
      check({nm, " zero wdata"}, {mem_wdata, gpu_wdata}, 32'h0);
    end
  endtask

  task automatic apply_table(input string nm);
    foreach (tbl[i]) apply_row(tbl[i], $sformatf("%s[%0d]", nm, i));
    tbl.delete();
  endtask

  initial begin
    vec_t v;
    reset      = 1'b1;
    copy_start = 1'b0;
    copy       = 1'b0;
    buttons    = 16'h0000;
    repeat (2) @(posedge clk);

    // Reset state, then copy_start without copy is ignored.
    v = mk(1'b0, 1'b0, 16'h0); v.rst = 1'b1; v.zero = 1'b1; tbl.push_back(v);
    v = mk(1'b1, 1'b0, 16'h0); v.zero = 1'b1; tbl.push_back(v);
    for (int i = 0; i < 3; i++) begin
      v = mk(1'b0, 1'b1, 16'h0); v.zero = 1'b1; tbl.push_back(v);
    end
    apply_table("idle");

    // Full transfer with buttons 0x00C3.
    add_transfer(16'h00C3, -1, 1'b0, -1);
    apply_table("xfer");

    // Second copy_start pulse mid-transfer must not disturb the sequence.
    add_transfer(16'h5A5A, 4, 1'b0, -1);
    apply_table("restart");

    // copy dropped at the fifth cycle after start: abort, overrun, no done.
    add_transfer(16'h0001, -1, 1'b0, 5);
    v = mk(1'b0, 1'b0, 16'h0001); v.busy_x = 1'b1; tbl.push_back(v);
    v = mk(1'b0, 1'b0, 16'h0001); v.ovr = 1'b1; tbl.push_back(v);
    for (int i = 0; i < 2; i++) begin
      v = mk(1'b0, 1'b1, 16'h0001); v.ovr = 1'b1; tbl.push_back(v);
    end
    apply_table("abort");

    // Next transfer clears overrun and completes.
    add_transfer(16'h0002, -1, 1'b1, -1);
    apply_table("recover");

    // Reset asserted six cycles after start: everything zero next cycle, nothing after.
    add_transfer(16'h0003, -1, 1'b0, 7);
    tbl[6].rst = 1'b1;
    v = mk(1'b0, 1'b1, 16'h0003); v.zero = 1'b1; tbl.push_back(v);
    for (int i = 0; i < 12; i++) begin
      v = mk(1'b0, 1'b1, 16'h0003); tbl.push_back(v);
    end
    apply_table("reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
